// File: rtl/decode_execute_reg_if.sv
// rtl/decode_execute_reg_if.sv - decode/execute pipeline register bundle interface
interface decode_execute_reg_if #(
    parameter int registerSize  = 32,
    parameter int vectorSize    = 4,
    parameter int selectionBits = 5,
    parameter int opBits        = 4
);
    // hazard control
    logic                                     stall;
    logic                                     flush;

    // decoded instruction entering the register
    logic                                     inValid;
    logic [opBits-1:0]                        inOp;
    logic                                     inRegWrEnSc;
    logic                                     inRegWrEnVec;
    logic [selectionBits-1:0]                 inRSel1;
    logic [selectionBits-1:0]                 inRSel2;
    logic [selectionBits-1:0]                 inRegToWrite;
    logic [vectorSize-1:0][registerSize-1:0]  inOperand1;
    logic [vectorSize-1:0][registerSize-1:0]  inOperand2;

    // writeback bus, observed for same-cycle bypass
    logic                                     wbRegWrEnSc;
    logic                                     wbRegWrEnVec;
    logic [selectionBits-1:0]                 wbRegToWrite;
    logic [vectorSize-1:0][registerSize-1:0]  wbData;

    // registered execute-stage bundle
    logic                                     outValid;
    logic [opBits-1:0]                        outOp;
    logic                                     outRegWrEnSc;
    logic                                     outRegWrEnVec;
    logic [selectionBits-1:0]                 outRegToWrite;
    logic [vectorSize-1:0][registerSize-1:0]  outOperand1;
    logic [vectorSize-1:0][registerSize-1:0]  outOperand2;
    logic [15:0]                              stallCount;

    // decode side / hazard unit drives, execute side observes
    modport master (
        output stall, flush,
        output inValid, inOp, inRegWrEnSc, inRegWrEnVec,
        output inRSel1, inRSel2, inRegToWrite, inOperand1, inOperand2,
        output wbRegWrEnSc, wbRegWrEnVec, wbRegToWrite, wbData,
        input  outValid, outOp, outRegWrEnSc, outRegWrEnVec,
        input  outRegToWrite, outOperand1, outOperand2, stallCount
    );

    // the pipeline register itself
    modport slave (
        input  stall, flush,
        input  inValid, inOp, inRegWrEnSc, inRegWrEnVec,
        input  inRSel1, inRSel2, inRegToWrite, inOperand1, inOperand2,
        input  wbRegWrEnSc, wbRegWrEnVec, wbRegToWrite, wbData,
        output outValid, outOp, outRegWrEnSc, outRegWrEnVec,
        output outRegToWrite, outOperand1, outOperand2, stallCount
    );
endinterface

// File: rtl/decode_execute_reg.sv
// rtl/decode_execute_reg.sv - decode/execute pipeline register, optional writeback bypass via DECODE_EXECUTE_REG_FORWARDING_EN
module decode_execute_reg #(
    parameter int registerSize  = 32,
    parameter int vectorSize    = 4,
    parameter int selectionBits = 5,
    parameter int opBits        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_execute_reg_if.slave  bus
);

    localparam int SEL_MSB = selectionBits - 1;

    typedef logic [vectorSize-1:0][registerSize-1:0] operand_t;

    operand_t capture1;
    operand_t capture2;

`ifdef DECODE_EXECUTE_REG_FORWARDING_EN
    logic     match1_sc;
    logic     match1_vec;
    logic     match2_sc;
    logic     match2_vec;
    operand_t wb_broadcast;

    // A hit needs the same select and the write enable of the matching register class
    always_comb begin
        match1_sc  = (bus.wbRegToWrite == bus.inRSel1) &&  bus.inRSel1[SEL_MSB] && bus.wbRegWrEnSc;
        match1_vec = (bus.wbRegToWrite == bus.inRSel1) && !bus.inRSel1[SEL_MSB] && bus.wbRegWrEnVec;
        match2_sc  = (bus.wbRegToWrite == bus.inRSel2) &&  bus.inRSel2[SEL_MSB] && bus.wbRegWrEnSc;
        match2_vec = (bus.wbRegToWrite == bus.inRSel2) && !bus.inRSel2[SEL_MSB] && bus.wbRegWrEnVec;
    end

    // A scalar result lives in lane 0; broadcast it so the operand looks like a splat
    always_comb begin
        wb_broadcast = '0;
        for (int i = 0; i < vectorSize; i++) begin
            wb_broadcast[i] = bus.wbData[0];
        end
    end

    // Pick the freshest value for each source operand
    always_comb begin
        capture1 = bus.inOperand1;
        capture2 = bus.inOperand2;
        if (match1_sc) begin
            capture1 = wb_broadcast;
        end else if (match1_vec) begin
            capture1 = bus.wbData;
        end
        if (match2_sc) begin
            capture2 = wb_broadcast;
        end else if (match2_vec) begin
            capture2 = bus.wbData;
        end
    end
`else
    logic unused_fwd_inputs;

    // Without bypass the decode-stage operands are taken as read
    always_comb begin
        capture1 = bus.inOperand1;
        capture2 = bus.inOperand2;
    end

    // Writeback and select ports stay on the boundary but have no effect here
    assign unused_fwd_inputs = ^{bus.wbRegWrEnSc, bus.wbRegWrEnVec, bus.wbRegToWrite,
                                 bus.wbData, bus.inRSel1, bus.inRSel2};
`endif

    // Pipeline bundle: reset beats flush beats stall; a flush only kills the side effects
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.outValid      <= 1'b0;
            bus.outOp         <= '0;
            bus.outRegWrEnSc  <= 1'b0;
            bus.outRegWrEnVec <= 1'b0;
            bus.outRegToWrite <= '0;
            bus.outOperand1   <= '0;
            bus.outOperand2   <= '0;
        end else if (bus.flush) begin
            bus.outValid      <= 1'b0;
            bus.outRegWrEnSc  <= 1'b0;
            bus.outRegWrEnVec <= 1'b0;
        end else if (!bus.stall) begin
            bus.outValid      <= bus.inValid;
            bus.outOp         <= bus.inOp;
            bus.outRegWrEnSc  <= bus.inValid & bus.inRegWrEnSc;
            bus.outRegWrEnVec <= bus.inValid & bus.inRegWrEnVec;
            bus.outRegToWrite <= bus.inRegToWrite;
            bus.outOperand1   <= capture1;
            bus.outOperand2   <= capture2;
        end
    end

    // Stall statistics: count only genuine holds, saturate rather than wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stallCount <= '0;
        end else if (bus.stall && !bus.flush && (bus.stallCount != 16'hFFFF)) begin
            bus.stallCount <= bus.stallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_execute_reg.sv
// tb/tb_decode_execute_reg.sv - self-checking bench for decode_execute_reg
module tb_decode_execute_reg;

    localparam int RS = 32;
    localparam int VS = 4;
    localparam int SB = 5;
    localparam int OB = 4;

`ifdef DECODE_EXECUTE_REG_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef logic [VS-1:0][RS-1:0] vec_t;

    typedef struct {
        logic          vld;
        logic [OB-1:0] op;
        logic          wsc;
        logic          wvec;
        logic [SB-1:0] rtw;
        vec_t          op1;
        vec_t          op2;
        logic [15:0]   cnt;
    } mdl_t;

    typedef struct {
        logic          rst;
        logic          stl;
        logic          fls;
        logic          vld;
        logic [OB-1:0] op;
        logic          wsc;
        logic          wvec;
        logic          e_vld;
        logic [OB-1:0] e_op;
        logic          e_wsc;
        logic          e_wvec;
        logic [15:0]   e_cnt;
    } rec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    mdl_t m;

    decode_execute_reg_if #(.registerSize(RS), .vectorSize(VS), .selectionBits(SB), .opBits(OB)) bus ();

    decode_execute_reg #(.registerSize(RS), .vectorSize(VS), .selectionBits(SB), .opBits(OB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t capture(logic [SB-1:0] sel, vec_t operand);
        vec_t r;
        r = operand;
        if (FWD && bus.wbRegToWrite == sel) begin
            if (sel[SB-1] && bus.wbRegWrEnSc) begin
                for (int i = 0; i < VS; i++) r[i] = bus.wbData[0];
            end else if (!sel[SB-1] && bus.wbRegWrEnVec) begin
                r = bus.wbData;
            end
        end
        return r;
    endfunction

    function automatic mdl_t model_next(mdl_t cur);
        mdl_t n;
        n = cur;
        if (reset) begin
            n.vld = 1'b0; n.op = '0; n.wsc = 1'b0; n.wvec = 1'b0;
            n.rtw = '0; n.op1 = '0; n.op2 = '0; n.cnt = 16'd0;
        end else if (bus.flush) begin
            n.vld = 1'b0; n.wsc = 1'b0; n.wvec = 1'b0;
        end else if (bus.stall) begin
            if (cur.cnt < 16'hFFFF) n.cnt = cur.cnt + 16'd1;
        end else begin
            n.vld  = bus.inValid;
            n.op   = bus.inOp;
            n.wsc  = bus.inValid && bus.inRegWrEnSc;
            n.wvec = bus.inValid && bus.inRegWrEnVec;
            n.rtw  = bus.inRegToWrite;
            n.op1  = capture(bus.inRSel1, bus.inOperand1);
            n.op2  = capture(bus.inRSel2, bus.inOperand2);
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".outValid"},      128'(bus.outValid),      128'(m.vld));
        chk({tag, ".outOp"},         128'(bus.outOp),         128'(m.op));
        chk({tag, ".outRegWrEnSc"},  128'(bus.outRegWrEnSc),  128'(m.wsc));
        chk({tag, ".outRegWrEnVec"}, 128'(bus.outRegWrEnVec), 128'(m.wvec));
        chk({tag, ".outRegToWrite"}, 128'(bus.outRegToWrite), 128'(m.rtw));
        chk({tag, ".outOperand1"},   128'(bus.outOperand1),   128'(m.op1));
        chk({tag, ".outOperand2"},   128'(bus.outOperand2),   128'(m.op2));
        chk({tag, ".stallCount"},    128'(bus.stallCount),    128'(m.cnt));
    endtask

    task automatic tick();
        m = model_next(m);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.inValid = 1'b0; bus.inOp = '0; bus.inRegWrEnSc = 1'b0; bus.inRegWrEnVec = 1'b0;
        bus.inRSel1 = '0; bus.inRSel2 = '0; bus.inRegToWrite = '0;
        bus.inOperand1 = '0; bus.inOperand2 = '0;
        bus.wbRegWrEnSc = 1'b0; bus.wbRegWrEnVec = 1'b0; bus.wbRegToWrite = '0; bus.wbData = '0;
    endtask

    rec_t tbl [10];
    vec_t exp_v;
    vec_t in_v;

    initial begin
        checks = 0;
        errors = 0;
        m.vld = 1'b0; m.op = '0; m.wsc = 1'b0; m.wvec = 1'b0;
        m.rtw = '0; m.op1 = '0; m.op2 = '0; m.cnt = 16'd0;
        idle();
        reset = 1'b1;

        //            rst   stl   fls   vld   op     wsc   wvec  e_vld e_op   e_wsc e_wvec e_cnt
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 16'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 16'd1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 16'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 16'd1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 16'd1};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};

        for (int i = 0; i < 10; i++) begin
            reset = tbl[i].rst;
            bus.stall = tbl[i].stl;
            bus.flush = tbl[i].fls;
            bus.inValid = tbl[i].vld;
            bus.inOp = tbl[i].op;
            bus.inRegWrEnSc = tbl[i].wsc;
            bus.inRegWrEnVec = tbl[i].wvec;
            bus.inRegToWrite = SB'(i + 1);
            for (int l = 0; l < VS; l++) begin
                in_v[l] = RS'(i * 16 + l);
            end
            bus.inOperand1 = in_v;
            bus.inOperand2 = ~in_v;
            tick();
            chk($sformatf("tbl%0d.outValid", i),      128'(bus.outValid),      128'(tbl[i].e_vld));
            chk($sformatf("tbl%0d.outOp", i),         128'(bus.outOp),         128'(tbl[i].e_op));
            chk($sformatf("tbl%0d.outRegWrEnSc", i),  128'(bus.outRegWrEnSc),  128'(tbl[i].e_wsc));
            chk($sformatf("tbl%0d.outRegWrEnVec", i), 128'(bus.outRegWrEnVec), 128'(tbl[i].e_wvec));
            chk($sformatf("tbl%0d.stallCount", i),    128'(bus.stallCount),    128'(tbl[i].e_cnt));
            check_model($sformatf("tbl%0d", i));
        end

        // reset for two cycles, then one instruction with one-cycle latency
        idle();
        reset = 1'b1;
        tick();
        tick();
        check_model("rst2");
        idle();
        bus.inValid = 1'b1;
        bus.inOp = 4'd3;
        for (int l = 0; l < VS; l++) exp_v[l] = RS'(l + 1);
        bus.inOperand1 = exp_v;
        tick();
        chk("lat.outValid",    128'(bus.outValid),    128'(1'b1));
        chk("lat.outOp",       128'(bus.outOp),       128'(4'd3));
        chk("lat.outOperand1", 128'(bus.outOperand1), 128'(exp_v));
        check_model("lat");

        // three stalls with changing inputs: frozen bundle, count of 3
        for (int k = 0; k < 3; k++) begin
            bus.stall = 1'b1;
            bus.inOp = OB'(k + 10);
            bus.inValid = k[0];
            bus.inOperand1 = {VS{RS'($urandom)}};
            tick();
        end
        chk("stall3.outOp",       128'(bus.outOp),       128'(4'd3));
        chk("stall3.outOperand1", 128'(bus.outOperand1), 128'(exp_v));
        chk("stall3.stallCount",  128'(bus.stallCount),  128'(16'd3));
        check_model("stall3");

        // drive the counter up to its ceiling
        bus.stall = 1'b1;
        for (int k = 0; k < 65531; k++) tick();
        chk("sat.fffe", 128'(bus.stallCount), 128'(16'hFFFE));
        for (int k = 0; k < 3; k++) tick();
        chk("sat.ffff", 128'(bus.stallCount), 128'(16'hFFFF));
        check_model("sat");

        // stall and flush together: flush wins, count holds
        bus.flush = 1'b1;
        bus.inValid = 1'b1;
        bus.inRegWrEnVec = 1'b1;
        tick();
        chk("sf.outValid",      128'(bus.outValid),      128'(1'b0));
        chk("sf.outRegWrEnVec", 128'(bus.outRegWrEnVec), 128'(1'b0));
        chk("sf.stallCount",    128'(bus.stallCount),    128'(16'hFFFF));

        // scalar source with a matching scalar writeback
        idle();
        bus.inValid = 1'b1;
        bus.inRSel1 = 5'b10011;
        bus.wbRegWrEnSc = 1'b1;
        bus.wbRegToWrite = 5'b10011;
        in_v = '0;
        in_v[0] = 32'h000000A5;
        bus.wbData = in_v;
        for (int l = 0; l < VS; l++) in_v[l] = RS'(32'h1000 + l);
        bus.inOperand1 = in_v;
        if (FWD) exp_v = {VS{32'h000000A5}};
        else exp_v = in_v;
        tick();
        chk("fwd_sc.outOperand1", 128'(bus.outOperand1), 128'(exp_v));

        // vector source but only the scalar enable set: never bypassed
        bus.inRSel1 = 5'b00011;
        bus.wbRegToWrite = 5'b00011;
        for (int l = 0; l < VS; l++) in_v[l] = RS'(32'h2000 + l);
        bus.inOperand1 = in_v;
        tick();
        chk("fwd_vec_sc.outOperand1", 128'(bus.outOperand1), 128'(in_v));
        check_model("fwd");

        // reset mid-stream while a valid instruction sits in the register
        bus.stall = 1'b1;
        tick();
        bus.stall = 1'b0;
        bus.inOp = 4'd12;
        tick();
        chk("mid.pre_valid", 128'(bus.outValid), 128'(1'b1));
        reset = 1'b1;
        tick();
        chk("mid.outValid",    128'(bus.outValid),    128'(1'b0));
        chk("mid.outOp",       128'(bus.outOp),       128'(4'd0));
        chk("mid.outOperand1", 128'(bus.outOperand1), 128'(0));
        chk("mid.stallCount",  128'(bus.stallCount),  128'(16'd0));
        check_model("mid");

        // randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 29) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 5) == 0);
            bus.inValid = 1'($urandom);
            bus.inOp = OB'($urandom);
            bus.inRegWrEnSc = 1'($urandom);
            bus.inRegWrEnVec = 1'($urandom);
            bus.inRSel1 = SB'($urandom);
            bus.inRSel2 = SB'($urandom);
            bus.inRegToWrite = SB'($urandom);
            for (int l = 0; l < VS; l++) begin
                in_v[l] = RS'($urandom);
            end
            bus.inOperand1 = in_v;
            for (int l = 0; l < VS; l++) begin
                in_v[l] = RS'($urandom);
            end
            bus.inOperand2 = in_v;
            case ($urandom_range(0, 2))
                0:       bus.wbRegToWrite = bus.inRSel1;
                1:       bus.wbRegToWrite = bus.inRSel2;
                default: bus.wbRegToWrite = SB'($urandom);
            endcase
            bus.wbRegWrEnSc = 1'($urandom);
            bus.wbRegWrEnVec = 1'($urandom);
            for (int l = 0; l < VS; l++) begin
                in_v[l] = RS'($urandom);
            end
            bus.wbData = in_v;
            tick();
            check_model($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
